// File: rtl/car_pkg.sv
// Shared car constants: microsecond tick rate, default sensor hold times and
// sensor channel indices, plus the hold-time selector used by sensor_deglitch.
package car_pkg;

   localparam int unsigned CLK_PER_US   = 50;
   localparam int unsigned SHORT_US_DEF = 10000;
   localparam int unsigned LONG_US_DEF  = 100000;

   typedef enum logic [1:0] {
      CH_IR_LEFT   = 2'd0,
      CH_IR_CENTER = 2'd1,
      CH_IR_RIGHT  = 2'd2,
      CH_HALL      = 2'd3
   } sensor_ch_e;

   function automatic int unsigned holdTicks(input bit isLong,
                                             input int unsigned shortUs,
                                             input int unsigned longUs);
      return isLong ? longUs : shortUs;
   endfunction

endpackage

// File: rtl/sensor_deglitch_if.sv
// Sensor-side bundle of sensor_deglitch: tick strobe, raw and conditioned
// levels, edge strobes and the glitch-counter readout.
interface sensor_deglitch_if #(
   parameter int N      = 4,
   parameter int GCNT_W = 8,
   parameter int SEL_W  = (N > 1) ? $clog2(N) : 1
);

   logic              tick_us;
   logic [N-1:0]      in;
   logic [N-1:0]      out;
   logic [N-1:0]      rise;
   logic [N-1:0]      fall;
   logic              any_change;
   logic              glitch_clr;
   logic [SEL_W-1:0]  glitch_sel;
   logic [GCNT_W-1:0] glitch_cnt;

   modport master (
      output tick_us, in, glitch_clr, glitch_sel,
      input  out, rise, fall, any_change, glitch_cnt
   );

   modport slave (
      input  tick_us, in, glitch_clr, glitch_sel,
      output out, rise, fall, any_change, glitch_cnt
   );

endinterface

// File: rtl/deglitch_ch.sv
// One sensor channel: synchroniser, hold counter, edge strobes and, when
// SENSOR_DEGLITCH_GCNT_EN is defined, a saturating glitch counter.
module deglitch_ch
   import car_pkg::*;
#(
   parameter int unsigned H           = SHORT_US_DEF,
   parameter int          CNT_W       = 17,
   parameter int          SYNC_STAGES = 2,
   parameter bit          RESET_VAL   = 1'b0,
   parameter int          GCNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_us_i,
   input  logic              in_i,
   input  logic              glitch_clr_i,
   output logic              out_o,
   output logic              rise_o,
   output logic              fall_o,
   output logic              toggle_o,
   output logic [GCNT_W-1:0] gcnt_o
);

   localparam logic [CNT_W-1:0]       LAST     = CNT_W'(H - 1);
   localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{RESET_VAL}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sLevel;
   logic                   out_q, out_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   toggle;
   logic                   glitch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= SYNC_RST;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign sLevel = sync_q[SYNC_STAGES-1];

   // Agreement with the output always wins, even on a tick that would finish the hold.
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      toggle = 1'b0;
      glitch = 1'b0;
      if (sLevel == out_q) begin
         cnt_d  = '0;
         glitch = (cnt_q != '0);
      end else if (tick_us_i) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            toggle = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_d = toggle & ~out_q;
   assign fall_d = toggle &  out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= RESET_VAL;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign out_o    = out_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign toggle_o = toggle;

`ifdef SENSOR_DEGLITCH_GCNT_EN
   logic [GCNT_W-1:0] gcnt_q, gcnt_d;

   always_comb begin
      gcnt_d = gcnt_q;
      if (glitch_clr_i)                 gcnt_d = '0;
      else if (glitch && gcnt_q != '1)  gcnt_d = gcnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) gcnt_q <= '0;
      else     gcnt_q <= gcnt_d;
   end

   assign gcnt_o = gcnt_q;
`else
   logic unusedGlitch;
   assign unusedGlitch = ^{glitch, glitch_clr_i};
   assign gcnt_o       = '0;
`endif

endmodule

// File: rtl/sensor_deglitch.sv
// N-channel sensor conditioner: per-channel deglitchers, the any_change OR and
// the glitch readout mux (storage only when SENSOR_DEGLITCH_GCNT_EN is defined).
module sensor_deglitch
   import car_pkg::*;
#(
   parameter int          N           = 4,
   parameter int unsigned SHORT_US    = SHORT_US_DEF,
   parameter int unsigned LONG_US     = LONG_US_DEF,
   parameter logic [N-1:0] LONG_MASK  = 'b0110,
   parameter int          CNT_W       = 17,
   parameter int          SYNC_STAGES = 2,
   parameter logic [N-1:0] RESET_VAL  = '0,
   parameter int          GCNT_W      = 8
) (
   input logic               clk,
   input logic               rst,
   sensor_deglitch_if.slave  bus
);

   localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]             outVec;
   logic [N-1:0]             riseVec;
   logic [N-1:0]             fallVec;
   logic [N-1:0]             toggleVec;
   logic [N-1:0][GCNT_W-1:0] gcnt;
   logic                     any_change_q;

   for (genvar i = 0; i < N; i++) begin : g_ch
      deglitch_ch #(
         .H           (holdTicks(LONG_MASK[i], SHORT_US, LONG_US)),
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .RESET_VAL   (RESET_VAL[i]),
         .GCNT_W      (GCNT_W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .tick_us_i    (bus.tick_us),
         .in_i         (bus.in[i]),
         .glitch_clr_i (bus.glitch_clr),
         .out_o        (outVec[i]),
         .rise_o       (riseVec[i]),
         .fall_o       (fallVec[i]),
         .toggle_o     (toggleVec[i]),
         .gcnt_o       (gcnt[i])
      );
   end

   // Registered from the same toggle terms as rise/fall so all strobes line up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) any_change_q <= 1'b0;
      else     any_change_q <= |toggleVec;
   end

   assign bus.out        = outVec;
   assign bus.rise       = riseVec;
   assign bus.fall       = fallVec;
   assign bus.any_change = any_change_q;

`ifdef SENSOR_DEGLITCH_GCNT_EN
   logic [GCNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

   always_comb begin
      glitch_cnt_d = '0;
      if (int'(bus.glitch_sel) < N) glitch_cnt_d = gcnt[bus.glitch_sel];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) glitch_cnt_q <= '0;
      else     glitch_cnt_q <= glitch_cnt_d;
   end

   assign bus.glitch_cnt = glitch_cnt_q;
`else
   logic unusedReadout;
   assign unusedReadout  = ^{bus.glitch_sel, gcnt};
   assign bus.glitch_cnt = '0;
`endif

   logic [SEL_W-1:0] unusedSelWidth;
   assign unusedSelWidth = bus.glitch_sel;

endmodule

// File: tb/tb_sensor_deglitch.sv
// Self-checking bench for sensor_deglitch: directed scenarios plus random
// stimulus compared every cycle against a tick-counting reference model.
module tb_sensor_deglitch;

   localparam int N           = 4;
   localparam int SHORT       = 4;
   localparam int LONG        = 8;
   localparam int SYNC        = 2;
   localparam int GW          = 8;
   localparam int TICK_PERIOD = 5;
   localparam int GMAX        = (1 << GW) - 1;
   localparam logic [N-1:0] MASK = 4'b0110;
`ifdef SENSOR_DEGLITCH_GCNT_EN
   localparam bit GCNT_ON = 1'b1;
`else
   localparam bit GCNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   sensor_deglitch_if #(.N(N), .GCNT_W(GW)) busIf ();

   sensor_deglitch #(
      .N(N), .SHORT_US(SHORT), .LONG_US(LONG), .LONG_MASK(MASK), .CNT_W(17),
      .SYNC_STAGES(SYNC), .RESET_VAL('0), .GCNT_W(GW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(busIf)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;
   bit tickAlways = 1'b0;
   int tickPhase = 0;
   bit prevTick = 1'b0;

   // Reference model: per channel, count qualifying ticks while the synchronised
   // level disagrees with the output; the output flips once the count reaches the hold.
   bit mSync [N][SYNC];
   bit mOut  [N];
   bit mRise [N];
   bit mFall [N];
   int mRun  [N];
   int mGl   [N];
   bit mAny;
   int mRead;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin : refModel
      int readNow;
      bit sLvl;
      int hold;
      if (rst) begin
         for (int c = 0; c < N; c++) begin
            mOut[c] = 1'b0; mRun[c] = 0; mGl[c] = 0; mRise[c] = 1'b0; mFall[c] = 1'b0;
            for (int k = 0; k < SYNC; k++) mSync[c][k] = 1'b0;
         end
         mAny  = 1'b0;
         mRead = 0;
      end else begin
         readNow = mGl[busIf.glitch_sel];
         mAny    = 1'b0;
         for (int c = 0; c < N; c++) begin
            sLvl     = mSync[c][SYNC-1];
            hold     = MASK[c] ? LONG : SHORT;
            mRise[c] = 1'b0;
            mFall[c] = 1'b0;
            if (sLvl != mOut[c]) begin
               if (busIf.tick_us) begin
                  mRun[c]++;
                  if (mRun[c] == hold) begin
                     mOut[c]  = ~mOut[c];
                     mRun[c]  = 0;
                     mRise[c] = mOut[c];
                     mFall[c] = ~mOut[c];
                     mAny     = 1'b1;
                  end
               end
            end else begin
               if (mRun[c] > 0) mGl[c] = (mGl[c] >= GMAX) ? GMAX : mGl[c] + 1;
               mRun[c] = 0;
            end
            if (busIf.glitch_clr) mGl[c] = 0;
            for (int k = SYNC - 1; k > 0; k--) mSync[c][k] = mSync[c][k-1];
            mSync[c][0] = busIf.in[c];
         end
         mRead = readNow;
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] eOut, eRise, eFall;
      if (checkEn) begin
         for (int c = 0; c < N; c++) begin
            eOut[c]  = mOut[c];
            eRise[c] = mRise[c];
            eFall[c] = mFall[c];
         end
         checkOutput("out",        busIf.out,        eOut);
         checkOutput("rise",       busIf.rise,       eRise);
         checkOutput("fall",       busIf.fall,       eFall);
         checkOutput("any_change", busIf.any_change, mAny);
         checkOutput("glitch_cnt", busIf.glitch_cnt, GCNT_ON ? mRead : 0);
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
      prevTick  = busIf.tick_us;
      tickPhase = (tickPhase + 1) % TICK_PERIOD;
      busIf.tick_us = tickAlways || (tickPhase == TICK_PERIOD - 1);
   endtask

   task automatic applyStimulus(input logic [N-1:0] inVec, input logic [1:0] sel, input logic clr);
      busIf.in         = inVec;
      busIf.glitch_sel = sel;
      busIf.glitch_clr = clr;
   endtask

   // Counts ticks seen from the first edge that uses the new synchronised level.
   task automatic runTicks(input int ch, input int stopTicks, output int ticks, output bit edgeSeen);
      int edges = 0;
      ticks = 0;
      edgeSeen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         stepCycle();
         edges++;
         if (edges >= SYNC + 1 && prevTick) ticks++;
         if (busIf.rise[ch] || busIf.fall[ch]) edgeSeen = 1'b1;
         if (edgeSeen || (stopTicks > 0 && ticks == stopTicks)) break;
      end
   endtask

   task automatic waitRunNonzero(input int ch);
      bit ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         stepCycle();
         if (mRun[ch] != 0) begin ok = 1'b1; break; end
      end
      checkOutput("wait_hold_start", ok, 1);
   endtask

   initial begin
      int ticks;
      bit seen;
      bit found;
      logic [N-1:0] inVec;
      logic [1:0] sel;

      busIf.tick_us = 1'b0;
      applyStimulus('0, 2'd0, 1'b0);
      repeat (3) stepCycle();
      checkEn = 1'b1;
      checkOutput("reset_out",        busIf.out,        0);
      checkOutput("reset_any_change", busIf.any_change, 0);
      checkOutput("reset_glitch_cnt", busIf.glitch_cnt, 0);
      rst = 1'b0;
      repeat (4) stepCycle();

      $display("[TB] short-channel rise");
      applyStimulus(4'b0001, 2'd0, 1'b0);
      runTicks(0, 0, ticks, seen);
      checkOutput("short_rise_seen",  seen, 1);
      checkOutput("short_rise_ticks", ticks, 4);
      checkOutput("short_rise_pulse", busIf.rise[0], 1);
      checkOutput("short_rise_any",   busIf.any_change, 1);
      checkOutput("short_rise_out",   busIf.out[0], 1);
      stepCycle();
      checkOutput("short_rise_once",  busIf.rise[0], 0);

      $display("[TB] long-channel glitch");
      applyStimulus(4'b0011, 2'd0, 1'b0);
      runTicks(1, 7, ticks, seen);
      checkOutput("long_glitch_ticks",   ticks, 7);
      checkOutput("long_glitch_no_edge", seen, 0);
      applyStimulus(4'b0001, 2'd0, 1'b0);
      repeat (4) stepCycle();
      checkOutput("long_glitch_out", busIf.out[1], 0);
      applyStimulus(4'b0001, 2'd1, 1'b0);
      stepCycle();
      checkOutput("long_glitch_cnt", busIf.glitch_cnt, GCNT_ON ? 1 : 0);

      $display("[TB] race between tick and return");
      applyStimulus(4'b0000, 2'd1, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         stepCycle();
         if (mRun[0] == 3 && tickPhase == 2) begin found = 1'b1; break; end
      end
      checkOutput("race_setup", found, 1);
      applyStimulus(4'b0001, 2'd1, 1'b0);
      seen = 1'b0;
      repeat (4) begin
         stepCycle();
         if (busIf.fall[0]) seen = 1'b1;
      end
      checkOutput("race_no_fall", seen, 0);
      checkOutput("race_out",     busIf.out[0], 1);
      applyStimulus(4'b0001, 2'd0, 1'b0);
      stepCycle();
      checkOutput("race_glitch_cnt", busIf.glitch_cnt, GCNT_ON ? 1 : 0);

      $display("[TB] reset mid-qualification");
      applyStimulus(4'b0101, 2'd0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         stepCycle();
         if (mRun[2] == 3) begin found = 1'b1; break; end
      end
      checkOutput("rst_setup", found, 1);
      rst = 1'b1;
      repeat (2) stepCycle();
      checkOutput("rst_out2",       busIf.out[2], 0);
      checkOutput("rst_glitch_cnt", busIf.glitch_cnt, 0);
      rst = 1'b0;
      runTicks(2, 0, ticks, seen);
      checkOutput("rst_rise_seen",  seen, 1);
      checkOutput("rst_rise_ticks", ticks, 8);
      checkOutput("rst_rise_out",   busIf.out[2], 1);

      $display("[TB] saturation and clear");
      inVec = busIf.in;
      for (int g = 0; g < 300; g++) begin
         inVec[3] = 1'b1;
         applyStimulus(inVec, 2'd3, 1'b0);
         waitRunNonzero(3);
         inVec[3] = 1'b0;
         applyStimulus(inVec, 2'd3, 1'b0);
         repeat (3) stepCycle();
      end
      stepCycle();
      checkOutput("sat_glitch_cnt", busIf.glitch_cnt, GCNT_ON ? GMAX : 0);
      checkOutput("sat_out3",       busIf.out[3], 0);
      inVec[3] = 1'b1;
      applyStimulus(inVec, 2'd3, 1'b0);
      waitRunNonzero(3);
      inVec[3] = 1'b0;
      applyStimulus(inVec, 2'd3, 1'b0);
      repeat (2) stepCycle();
      applyStimulus(inVec, 2'd3, 1'b1);
      stepCycle();
      applyStimulus(inVec, 2'd3, 1'b0);
      stepCycle();
      checkOutput("clr_glitch_cnt", busIf.glitch_cnt, 0);

      $display("[TB] random stimulus");
      sel = 2'd0;
      for (int c = 0; c < 4000; c++) begin
         tickAlways = (c >= 3000 && c < 3600);
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, 23) == 0) inVec[k] = ~inVec[k];
         if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, N - 1));
         applyStimulus(inVec, sel, $urandom_range(0, 199) == 0);
         rst = ($urandom_range(0, 999) == 0);
         stepCycle();
      end
      rst = 1'b0;
      tickAlways = 1'b0;
      repeat (3) stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_deglitch.md
# sensor_deglitch

Parametrised N-channel input conditioner for the car's binary sensors (IR line sensors, hall sensor). It replaces the per-channel fixed debouncers with one block. Each channel is synchronised, then qualified over either a short or a long per-channel hold time counted in microsecond ticks. The block emits a clean level, single-cycle edge strobes and an optional glitch statistic. It sits between the sensor pins and the tracking/U-turn controller and Core.

## Interface
- N, default 4: number of channels.
- SHORT_US, default 10000: hold time, in ticks, for channels whose LONG_MASK bit is 0. Must be ≥ 1.
- LONG_US, default 100000: hold time, in ticks, for channels whose LONG_MASK bit is 1. Must be ≥ 1.
- LONG_MASK, default 4'b0110: per-channel selection of the hold time.
- CNT_W, default 17: hold counter width. Must satisfy 2^CNT_W > max(SHORT_US, LONG_US) − 1.
- SYNC_STAGES, default 2: synchroniser depth. Must be ≥ 2.
- RESET_VAL, default all 0: per-channel reset level of `out`.
- GCNT_W, default 8: glitch counter width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- tick_us  in  1  one-clk strobe, once per µs.
- in  in  N  raw asynchronous sensor levels.
- out  out  N  debounced levels.
- rise  out  N  one-clk strobe when `out[i]` goes 0→1.
- fall  out  N  one-clk strobe when `out[i]` goes 1→0.
- any_change  out  1  OR of all `rise` and `fall` bits, registered together with them.
- glitch_clr  in  1  synchronous clear of all glitch counters.
- glitch_sel  in  $clog2(N)  channel selected for readout.
- glitch_cnt  out  GCNT_W  glitch count of the selected channel.

## Operation
Each channel runs independently:
- **Synchroniser:** `in[i]` passes through SYNC_STAGES flops, giving `s[i]`.
- **Qualify (`s ≠ out`):**
  - On each `tick_us`, `cnt` increments.
  - On the tick where `cnt == H−1`, `out` toggles and `cnt` clears to 0. H is LONG_US or SHORT_US, chosen by LONG_MASK[i].
  - `rise` or `fall` asserts for exactly the clk cycle in which `out` changes.
- **Idle (`s == out`):** `cnt` clears to 0.
  - If `cnt` was nonzero, the transition is a glitch: `gcnt[i]` increments and saturates at 2^GCNT_W − 1.
- **Simultaneous `tick_us` and return to equality:** equality wins. `cnt` clears, no toggle occurs, and a glitch is counted.
- **`glitch_clr` coincident with a glitch:** clear wins, and the counter reads 0.
- **`glitch_cnt` readout:** registered mux of `gcnt[glitch_sel]`. A `glitch_sel` value ≥ N reads 0.
- **Reset (asserted at any time, including mid-qualification):** synchroniser flops = RESET_VAL, `out` = RESET_VAL, `cnt` = 0, `rise`/`fall`/`any_change` = 0, `gcnt` = 0, `glitch_cnt` = 0.
  - After release, a channel whose `in` differs from RESET_VAL qualifies normally, with a full H ticks.
- **`tick_us` held high permanently:** legal; the hold time becomes H clk cycles.

## Timing
- **Latency from a stable `in` change to `out`:** SYNC_STAGES clk cycles, plus H `tick_us` strobes, plus 1 registered clk cycle.
  - `out` updates on the clk edge following the H-th qualifying tick.
  - `rise`/`fall` are coincident with the `out` change.
- **Minimum spacing between two `out` toggles on one channel:** H ticks.
- **`glitch_cnt`:** 1 clk latency from a `gcnt` change or a `glitch_sel` change.
- **`cnt`:** never exceeds H−1. No wrap-around is possible by construction.

## Configuration
- `SENSOR_DEGLITCH_GCNT_EN` defined: glitch counters, `glitch_clr`, `glitch_sel` and `glitch_cnt` are implemented as described.
- Macro undefined:
  - No glitch-counter storage is synthesised.
  - `glitch_cnt` is tied to 0.
  - `glitch_clr` and `glitch_sel` are ignored.
  - All other behaviour is unchanged.

## Structure
- **Shared package `car_pkg`:** the µs tick rate constant (50 clk per µs), the default SHORT_US and LONG_US hold times, and the IR channel index constants.
- **Sub-module `deglitch_ch`:** one channel, containing the synchroniser, hold counter, edge strobes and glitch counter. It is instantiated N times in a generate loop with its H resolved from LONG_MASK.
- **Top level of `sensor_deglitch`:** only the `any_change` OR and the readout mux.

## Test plan
Bench parameters: N=4, SHORT_US=4, LONG_US=8, LONG_MASK=4'b0110, SYNC_STAGES=2, tick_us high every 5 clk.
- **Short-channel rise:** `in[0]` 0→1 and held → `out[0]` = 1 and `rise[0]` pulses exactly once, on the 4th tick after sync. `any_change` pulses in the same cycle.
- **Long-channel glitch:** `in[1]` high for 7 ticks, then low → `out[1]` stays 0 and `gcnt[1]` = 1. With `glitch_sel`=1, `glitch_cnt` reads 1 one clk later.
- **Race:** `in[0]` returns to `out` in the same clk as the 4th tick → no toggle, and a glitch is counted.
- **Reset mid-qualification:** `rst` pulsed after 3 ticks of `in[2]` = 1 → `out[2]` stays 0. After release, `out[2]` rises 8 ticks after sync.
- **Saturation and clear:**
  - 300 glitches on channel 3 → `glitch_cnt` = 255.
  - `glitch_clr` together with a new glitch → `glitch_cnt` = 0.
- **Macro off:** scenario 2 repeated → `glitch_cnt` stays 0, and `out`, `rise`, `fall` and `any_change` match the macro-on run cycle for cycle.
